// File: rtl/game_sequencer.sv
// Game flow controller: tick generation, step-enable gating, serve pulses,
// life counter and game-over/win flags for the paddle/ball game.
module game_sequencer #(
  parameter int TICK_DIV  = 50_000_000 / 16,
  parameter int BALL_DIV  = 2,
  parameter int LIVES     = 3,
  parameter int MISS_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_p,
  input  logic       pause_p,
  input  logic       fall_down,
  input  logic       bricks_clear,
  output logic       board_step_en,
  output logic       ball_step_en,
  output logic       board_rst,
  output logic       ball_rst,
  output logic [1:0] life,
  output logic       fin,
  output logic       win,
  output logic [2:0] game_state
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int BW = (BALL_DIV > 1) ? $clog2(BALL_DIV) : 1;
  localparam int MW = (MISS_HOLD > 1) ? $clog2(MISS_HOLD) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_MISS  = 3'd4,
    S_OVER  = 3'd5,
    S_WIN   = 3'd6
  } state_t;

  state_t        state, state_next, prev_state;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [BW-1:0] ball_cnt;
  logic [MW-1:0] miss_cnt;
  logic          serve_first;
  logic          load_game;
  logic          lose_life;

  assign tick        = (tick_cnt == TW'(TICK_DIV - 1));
  assign serve_first = (state == S_SERVE) && (prev_state != S_SERVE);
  assign game_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // prev_state lets SERVE recognise its first cycle for the re-serve pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      prev_state <= S_IDLE;
    end else begin
      state      <= state_next;
      prev_state <= state;
    end
  end

  always_comb begin
    state_next    = state;
    board_rst     = 1'b0;
    ball_rst      = 1'b0;
    board_step_en = 1'b0;
    ball_step_en  = 1'b0;
    load_game     = 1'b0;
    lose_life     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_p) begin
          state_next = S_SERVE;
          load_game  = 1'b1;
        end
      end
      S_SERVE: begin
        board_rst = serve_first;
        ball_rst  = serve_first;
        if (start_p && !serve_first) state_next = S_PLAY;
      end
      S_PLAY: begin
        board_step_en = tick;
        ball_step_en  = tick && (ball_cnt == BW'(BALL_DIV - 1));
        if (bricks_clear) begin
          state_next = S_WIN;
        end else if (fall_down) begin
          state_next = S_MISS;
          lose_life  = 1'b1;
        end else if (pause_p) begin
          state_next = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (pause_p) state_next = S_PLAY;
      end
      S_MISS: begin
        if (tick && (miss_cnt == MW'(MISS_HOLD - 1))) begin
          state_next = (life != 2'd0) ? S_SERVE : S_OVER;
        end
      end
      S_OVER: begin
        if (start_p) state_next = S_IDLE;
      end
      S_WIN: begin
        if (start_p) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ball_cnt is held outside PLAY so a pause resumes mid-period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ball_cnt <= '0;
    end else if (state == S_SERVE) begin
      ball_cnt <= '0;
    end else if ((state == S_PLAY) && tick) begin
      if (ball_cnt == BW'(BALL_DIV - 1)) ball_cnt <= '0;
      else                               ball_cnt <= ball_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt <= '0;
    end else if (state != S_MISS) begin
      miss_cnt <= '0;
    end else if (tick) begin
      miss_cnt <= miss_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      life <= 2'(LIVES);
      fin  <= 1'b0;
      win  <= 1'b0;
    end else begin
      if (load_game) begin
        life <= 2'(LIVES);
        fin  <= 1'b0;
        win  <= 1'b0;
      end else if (lose_life && (life != 2'd0)) begin
        life <= life - 2'd1;
      end
      if ((state == S_MISS) && (state_next == S_OVER)) fin <= 1'b1;
      if ((state == S_PLAY) && (state_next == S_WIN))  win <= 1'b1;
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer with a short tick (TICK_DIV=4,
// BALL_DIV=2, LIVES=3, MISS_HOLD=2): vector table plus multi-cycle sequences.
module tb_game_sequencer;

  localparam int ST_IDLE  = 0;
  localparam int ST_SERVE = 1;
  localparam int ST_PLAY  = 2;
  localparam int ST_PAUSE = 3;
  localparam int ST_MISS  = 4;
  localparam int ST_OVER  = 5;
  localparam int ST_WIN   = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_p = 1'b0;
  logic       pause_p = 1'b0;
  logic       fall_down = 1'b0;
  logic       bricks_clear = 1'b0;
  logic       board_step_en;
  logic       ball_step_en;
  logic       board_rst;
  logic       ball_rst;
  logic [1:0] life;
  logic       fin;
  logic       win;
  logic [2:0] game_state;

  int checks = 0;
  int errors = 0;
  int cyc;

  typedef struct {
    logic       s, p, f, c;
    logic [2:0] st;
    logic       rst;
    logic [1:0] life;
    logic       fin, win;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  game_sequencer #(
    .TICK_DIV(4), .BALL_DIV(2), .LIVES(3), .MISS_HOLD(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_p(start_p), .pause_p(pause_p),
    .fall_down(fall_down), .bricks_clear(bricks_clear),
    .board_step_en(board_step_en), .ball_step_en(ball_step_en),
    .board_rst(board_rst), .ball_rst(ball_rst), .life(life),
    .fin(fin), .win(win), .game_state(game_state)
  );

  // Reference timebase: cycles since reset release, tick every 4th cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic tick_exp();
    return (cyc % 4) == 3;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge: drive inputs, pass one posedge, land on the next negedge
  task automatic applyStimulus(input logic s, input logic p, input logic f, input logic c);
    start_p = s; pause_p = p; fall_down = f; bricks_clear = c;
    @(negedge clk);
    start_p = 1'b0; pause_p = 1'b0; fall_down = 1'b0; bricks_clear = 1'b0;
  endtask

  task automatic wait_board(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (board_step_en) begin
        ok = 1'b1;
        return;
      end
      applyStimulus(0, 0, 0, 0);
    end
  endtask

  // From PLAY: lose a ball, sit out MISS, then land in exp_final
  task automatic lose_one(input int exp_life, input int exp_final);
    int  ticks;
    int  quiet_bad;
    bit  left;
    applyStimulus(0, 0, 1, 0);
    checkOutput("miss_state", int'(game_state), ST_MISS);
    checkOutput("miss_life", int'(life), exp_life);
    ticks = 0; quiet_bad = 0; left = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (int'(game_state) != ST_MISS) begin
        left = 1'b1;
        break;
      end
      if (tick_exp()) ticks++;
      if (board_step_en || ball_step_en) quiet_bad++;
      applyStimulus(0, 0, 0, 0);
    end
    checkOutput("miss_exit_in_time", int'(left), 1);
    checkOutput("miss_ticks", ticks, 2);
    checkOutput("miss_enables_quiet", quiet_bad, 0);
    checkOutput("after_miss_state", int'(game_state), exp_final);
    if (exp_final == ST_SERVE) begin
      checkOutput("reserve_board_rst", int'(board_rst), 1);
      checkOutput("reserve_ball_rst", int'(ball_rst), 1);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      checkOutput("reserve_play", int'(game_state), ST_PLAY);
    end
  endtask

  task automatic start_game();
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("start_game_play", int'(game_state), ST_PLAY);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int board_n, ball_n, board_first, board_last, ball_first, ball_last;
    int quiet_bad, tick_bad;
    bit ok;

    vecs[0] = '{s:1, p:0, f:0, c:0, st:ST_SERVE, rst:1, life:3, fin:0, win:0};
    vecs[1] = '{s:1, p:0, f:0, c:0, st:ST_SERVE, rst:0, life:3, fin:0, win:0};
    vecs[2] = '{s:0, p:0, f:0, c:0, st:ST_SERVE, rst:0, life:3, fin:0, win:0};
    vecs[3] = '{s:1, p:0, f:0, c:0, st:ST_PLAY,  rst:0, life:3, fin:0, win:0};
    vecs[4] = '{s:1, p:1, f:0, c:0, st:ST_PAUSE, rst:0, life:3, fin:0, win:0};
    vecs[5] = '{s:1, p:0, f:0, c:0, st:ST_PAUSE, rst:0, life:3, fin:0, win:0};
    vecs[6] = '{s:0, p:0, f:1, c:1, st:ST_PAUSE, rst:0, life:3, fin:0, win:0};
    vecs[7] = '{s:0, p:1, f:0, c:0, st:ST_PLAY,  rst:0, life:3, fin:0, win:0};

    repeat (2) @(negedge clk);
    checkOutput("reset_state", int'(game_state), ST_IDLE);
    checkOutput("reset_life", int'(life), 3);
    checkOutput("reset_fin", int'(fin), 0);
    checkOutput("reset_win", int'(win), 0);
    checkOutput("reset_pulses", int'({board_step_en, ball_step_en, board_rst, ball_rst}), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].s, vecs[i].p, vecs[i].f, vecs[i].c);
      checkOutput($sformatf("vec%0d_state", i), int'(game_state), int'(vecs[i].st));
      checkOutput($sformatf("vec%0d_board_rst", i), int'(board_rst), int'(vecs[i].rst));
      checkOutput($sformatf("vec%0d_ball_rst", i), int'(ball_rst), int'(vecs[i].rst));
      checkOutput($sformatf("vec%0d_life", i), int'(life), int'(vecs[i].life));
      checkOutput($sformatf("vec%0d_fin", i), int'(fin), int'(vecs[i].fin));
      checkOutput($sformatf("vec%0d_win", i), int'(win), int'(vecs[i].win));
      if (int'(vecs[i].st) == ST_PLAY)
        checkOutput($sformatf("vec%0d_board_en", i), int'(board_step_en), int'(tick_exp()));
      else
        checkOutput($sformatf("vec%0d_enables", i), int'({board_step_en, ball_step_en}), 0);
    end

    // 16 PLAY cycles: 4 paddle steps 4 apart, 2 ball steps 8 apart
    board_n = 0; ball_n = 0; tick_bad = 0;
    board_first = -1; board_last = -1; ball_first = -1; ball_last = -1;
    for (int i = 0; i < 16; i++) begin
      if (board_step_en != tick_exp()) tick_bad++;
      if (board_step_en) begin
        if (board_first < 0) board_first = i;
        board_last = i;
        board_n++;
      end
      if (ball_step_en) begin
        if (ball_first < 0) ball_first = i;
        ball_last = i;
        ball_n++;
      end
      applyStimulus(0, 0, 0, 0);
    end
    checkOutput("play_board_pulses", board_n, 4);
    checkOutput("play_board_span", board_last - board_first, 12);
    checkOutput("play_ball_pulses", ball_n, 2);
    checkOutput("play_ball_span", ball_last - ball_first, 8);
    checkOutput("play_board_vs_tick", tick_bad, 0);

    lose_one(2, ST_SERVE);
    lose_one(1, ST_SERVE);
    lose_one(0, ST_OVER);
    checkOutput("over_fin", int'(fin), 1);
    checkOutput("over_life", int'(life), 0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("over_hold", int'(game_state), ST_OVER);
    checkOutput("over_fin_hold", int'(fin), 1);
    applyStimulus(1, 0, 0, 0);
    checkOutput("over_start_idle", int'(game_state), ST_IDLE);

    // Simultaneous fall_down and bricks_clear: win takes priority, no life lost
    start_game();
    checkOutput("win_fin_cleared", int'(fin), 0);
    applyStimulus(0, 0, 1, 1);
    checkOutput("win_state", int'(game_state), ST_WIN);
    checkOutput("win_flag", int'(win), 1);
    checkOutput("win_life", int'(life), 3);
    applyStimulus(0, 0, 1, 0);
    checkOutput("win_hold", int'(game_state), ST_WIN);
    applyStimulus(1, 0, 0, 0);
    checkOutput("win_start_idle", int'(game_state), ST_IDLE);

    // Pause after one tick (ball_cnt=1); first tick after resume must step the ball
    start_game();
    wait_board(ok);
    checkOutput("pause_first_tick_seen", int'(ok), 1);
    checkOutput("pause_first_tick_no_ball", int'(ball_step_en), 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("pause_state", int'(game_state), ST_PAUSE);
    quiet_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (board_step_en || ball_step_en || int'(game_state) != ST_PAUSE) quiet_bad++;
      applyStimulus(0, 0, (i == 5), (i == 10));
    end
    checkOutput("pause_quiet_20clk", quiet_bad, 0);
    checkOutput("pause_life_kept", int'(life), 3);
    applyStimulus(0, 1, 0, 0);
    checkOutput("resume_state", int'(game_state), ST_PLAY);
    wait_board(ok);
    checkOutput("resume_tick_seen", int'(ok), 1);
    checkOutput("resume_ball_step", int'(ball_step_en), 1);

    // Asynchronous reset in the middle of MISS
    applyStimulus(0, 0, 1, 0);
    checkOutput("rst_pre_miss", int'(game_state), ST_MISS);
    checkOutput("rst_pre_life", int'(life), 2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_state", int'(game_state), ST_IDLE);
    checkOutput("rst_async_life", int'(life), 3);
    checkOutput("rst_async_fin", int'(fin), 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_game();
    tick_bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (board_step_en != tick_exp()) tick_bad++;
      applyStimulus(0, 0, 0, 0);
    end
    checkOutput("rst_tick_restart", tick_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
